reg_write_arbiter: RTL and testbench
====================================

Name: reg_write_arbiter

Overview:
- Round-robin arbiter that shares write access to one N-bit register (output Y) among M requesters.
- Each write uses a req/gnt/ack handshake.
- Sits in front of the register datapath and serialises writes from several masters.
- Exposes a busy flag and a wrapping write counter for the testbench and for debug.

Parameters:
- N, 10, register data width in bits.
- M, 4, number of requesters (M >= 2).
- CW, 8, width of the write counter.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous reset, active-high.
- req  input  M  req[i] high = requester i wants a write; held until ack[i] or abort.
- data  input  M*N  slice i (bits i*N+N-1 : i*N) = write data of requester i; stable while req[i] is high.
- gnt  output  M  one-hot grant, registered.
- ack  output  M  one-hot, one-cycle write-done pulse, registered.
- Y  output  N  register contents.
- busy  output  1  high whenever the FSM is not in IDLE.
- wr_cnt  output  CW  number of completed writes, modulo 2^CW.

Behaviour:
- Reset: rst high clears everything immediately, independent of clk.
  - Y=0, gnt=0, ack=0, busy=0, wr_cnt=0.
  - Priority pointer ptr=0, FSM returns to IDLE.
  - Reset asserted mid-operation (GRANT or ACK) aborts the write; no ack is produced after rst falls.
- FSM states: IDLE, GRANT, ACK.
- IDLE:
  - If req==0: stay in IDLE, gnt=0.
  - Otherwise pick winner w = first set req bit scanning ptr, ptr+1, ..., wrapping mod M.
  - Next edge: gnt <= onehot(w), state <= GRANT, busy <= 1.
- GRANT:
  - If req[w] is still high: next edge Y <= data slice w, ack <= onehot(w), gnt <= 0, wr_cnt <= wr_cnt+1, state <= ACK.
  - If req[w] is low (abort): next edge gnt <= 0, state <= IDLE, busy <= 0. Y, ack and wr_cnt are unchanged.
  - Either way, ptr <= (w+1) mod M on that edge.
- ACK:
  - Next edge: ack <= 0, state <= IDLE, busy <= 0.
  - The requester must drop req[w] before this edge.
  - A req[w] still high at the next IDLE sample counts as a new request.
- Latency: request sampled at edge k -> gnt visible after edge k -> Y and ack visible after edge k+1 -> busy low after edge k+2.
  - Maximum throughput: one write per 3 cycles.
- Requests from other requesters during GRANT/ACK are ignored until IDLE; they are never lost while held high.
- gnt and ack are never both nonzero in the same cycle. Each is zero or one-hot.
- wr_cnt wraps from 2^CW-1 to 0 with no flag.
- Y changes only on a completed write or on reset.
- Changes to data[w] while in GRANT are legal; the value present at the GRANT->ACK edge is the one written.

Test Plan:
- Reset: rst=1 for 1 cycle at any point -> Y=0, gnt=0, ack=0, busy=0, wr_cnt=0 immediately, before the next clk edge.
- Single write: req=4'b0010, data slice1=10'h155 -> gnt=0010 for 1 cycle, then Y=10'h155 and ack=0010 for 1 cycle; wr_cnt=1; busy high for 2 cycles.
- All request: req=4'b1111 from reset, each requester drops req after its ack -> grant order 0,1,2,3 with data slices 10'h001, 10'h002, 10'h003, 10'h004 -> Y takes those values in turn; wr_cnt=4; one ack every 3 cycles.
- Fairness: after a completed grant to requester 2 (ptr=3), req=4'b0101 -> requester 0 is granted first, then requester 2.
- Abort: requester 1 drops req while gnt=0010 -> no ack, Y unchanged, wr_cnt unchanged, FSM back in IDLE, ptr=2.
- Reset mid-write and counter wrap:
  - rst asserted while in ACK -> ack and busy low at once, Y=0.
  - Separately, with CW=2, 4 completed writes -> wr_cnt returns to 0.

Source files
------------

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter serialising writes from M requesters into one N-bit register.
// Each write is a req -> gnt -> ack handshake; busy and a wrapping write counter aid debug.
module reg_write_arbiter #(
  parameter int N  = 10,
  parameter int M  = 4,
  parameter int CW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [M-1:0]    req,
  input  logic [M*N-1:0]  data,
  output logic [M-1:0]    gnt,
  output logic [M-1:0]    ack,
  output logic [N-1:0]    Y,
  output logic            busy,
  output logic [CW-1:0]   wr_cnt
);

  localparam int PW = $clog2(M);

  typedef enum logic [1:0] {IDLE, GRANT, ACK} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   w_q, w_d;
  logic [M-1:0]    gnt_q, gnt_d;
  logic [M-1:0]    ack_q, ack_d;
  logic [N-1:0]    y_q, y_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N-1:0]    sel_data;
  logic            sel_req;

  // First set request bit scanning upward from p, wrapping modulo M.
  function automatic logic [PW-1:0] pick(input logic [M-1:0] r, input logic [PW-1:0] p);
    logic [PW-1:0] w;
    w = '0;
    for (int k = M-1; k >= 0; k--) begin
      for (int j = 0; j < M; j++) begin
        if ((j == ((int'(p) + k) % M)) && r[j]) w = PW'(j);
      end
    end
    return w;
  endfunction

  function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] i);
    if (int'(i) == M-1) return '0;
    return i + 1'b1;
  endfunction

  function automatic logic [M-1:0] onehot(input logic [PW-1:0] i);
    return {{(M-1){1'b0}}, 1'b1} << i;
  endfunction

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    w_d      = w_q;
    gnt_d    = '0;
    ack_d    = '0;
    y_d      = y_q;
    cnt_d    = cnt_q;
    sel_data = '0;
    sel_req  = 1'b0;
    for (int i = 0; i < M; i++) begin
      if (w_q == PW'(i)) begin
        sel_data = data[i*N +: N];
        sel_req  = req[i];
      end
    end
    case (state_q)
      IDLE: begin
        if (|req) begin
          w_d     = pick(req, ptr_q);
          gnt_d   = onehot(w_d);
          state_d = GRANT;
        end
      end
      GRANT: begin
        // Pointer advances past the winner whether the write completes or aborts.
        ptr_d = next_idx(w_q);
        if (sel_req) begin
          y_d     = sel_data;
          ack_d   = onehot(w_q);
          cnt_d   = cnt_q + 1'b1;
          state_d = ACK;
        end else begin
          state_d = IDLE;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      w_q     <= '0;
      gnt_q   <= '0;
      ack_q   <= '0;
      y_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      w_q     <= w_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      y_q     <= y_d;
      cnt_q   <= cnt_d;
    end
  end

  assign gnt    = gnt_q;
  assign ack    = ack_q;
  assign Y      = y_q;
  assign busy   = (state_q != IDLE);
  assign wr_cnt = cnt_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Bench for reg_write_arbiter: directed scenarios plus randomized traffic against a
// transaction-level model (pointer, register value, write count).
module tb_reg_write_arbiter;
  localparam int N  = 10;
  localparam int M  = 4;
  localparam int CW = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [M-1:0]   req;
  logic [N-1:0]   dsl [M];
  logic [M*N-1:0] data;
  logic [M-1:0]   gnt, ack, gnt_w, ack_w;
  logic [N-1:0]   y, y_w;
  logic           busy, busy_w;
  logic [CW-1:0]  wr_cnt;
  logic [1:0]     wr_cnt_w;

  int n_checks = 0;
  int n_fail   = 0;

  int          m_ptr = 0;
  int          m_cnt = 0;
  logic [N-1:0] m_y  = '0;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < M; i++) data[i*N +: N] = dsl[i];
  end

  reg_write_arbiter #(.N(N), .M(M), .CW(CW)) dut (
    .clk(clk), .rst(rst), .req(req), .data(data),
    .gnt(gnt), .ack(ack), .Y(y), .busy(busy), .wr_cnt(wr_cnt)
  );

  reg_write_arbiter #(.N(N), .M(M), .CW(2)) dut_w (
    .clk(clk), .rst(rst), .req(req), .data(data),
    .gnt(gnt_w), .ack(ack_w), .Y(y_w), .busy(busy_w), .wr_cnt(wr_cnt_w)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int model_pick(input logic [M-1:0] r);
    for (int i = 0; i < M; i++)
      for (int j = 0; j < M; j++)
        if ((j == (m_ptr + i) % M) && r[j]) return j;
    return 0;
  endfunction

  function automatic logic [M-1:0] oh(input int k);
    logic [M-1:0] one;
    one = 1;
    return one << k;
  endfunction

  task automatic model_reset();
    m_ptr = 0;
    m_cnt = 0;
    m_y   = '0;
  endtask

  task automatic model_grant_edge(input int w, input bit done);
    m_ptr = (w + 1) % M;
    if (done) begin
      m_cnt = m_cnt + 1;
      m_y   = dsl[w];
    end
  endtask

  function automatic logic [28:0] obs();
    return {gnt, ack, busy, y, wr_cnt, wr_cnt_w};
  endfunction

  function automatic logic [28:0] exp_vec(input logic [M-1:0] g, input logic [M-1:0] a, input logic b);
    return {g, a, b, m_y, CW'(m_cnt), 2'(m_cnt)};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    req = '0;
    for (int i = 0; i < M; i++) dsl[i] = '0;
    model_reset();
    tick();
    n_checks++;
    if (obs() !== exp_vec('0, '0, 1'b0)) begin
      n_fail++;
      $display("FAIL reset_hold: got %h want %h", obs(), exp_vec('0, '0, 1'b0));
    end
    rst = 1'b0;
    tick();
    tick();
    n_checks++;
    if (obs() !== exp_vec('0, '0, 1'b0)) begin
      n_fail++;
      $display("FAIL reset_idle: got %h want %h", obs(), exp_vec('0, '0, 1'b0));
    end
  endtask

  task automatic pulse_reset(input string name);
    rst = 1'b1;
    #1;
    model_reset();
    n_checks++;
    if (obs() !== exp_vec('0, '0, 1'b0)) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, obs(), exp_vec('0, '0, 1'b0));
    end
    #1;
    rst = 1'b0;
  endtask

  task automatic test_single();
    int w;
    dsl[1] = 10'h155;
    req    = 4'b0010;
    w      = model_pick(req);
    tick();
    n_checks++;
    if (obs() !== exp_vec(oh(w), '0, 1'b1)) begin
      n_fail++;
      $display("FAIL single_grant: got %h want %h", obs(), exp_vec(oh(w), '0, 1'b1));
    end
    tick();
    model_grant_edge(w, 1'b1);
    n_checks++;
    if (obs() !== exp_vec('0, oh(w), 1'b1) || y !== 10'h155) begin
      n_fail++;
      $display("FAIL single_ack: got %h want %h", obs(), exp_vec('0, oh(w), 1'b1));
    end
    req = '0;
    tick();
    n_checks++;
    if (obs() !== exp_vec('0, '0, 1'b0)) begin
      n_fail++;
      $display("FAIL single_idle: got %h want %h", obs(), exp_vec('0, '0, 1'b0));
    end
  endtask

  task automatic test_all_request();
    int w;
    pulse_reset("all_req_reset");
    for (int i = 0; i < M; i++) dsl[i] = N'(i + 1);
    req = '1;
    for (int i = 0; i < M; i++) begin
      w = model_pick(req);
      tick();
      n_checks++;
      if (gnt !== oh(i) || ack !== '0 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL all_req_grant%0d: got gnt=%b ack=%b busy=%b want gnt=%b", i, gnt, ack, busy, oh(i));
      end
      tick();
      model_grant_edge(w, 1'b1);
      n_checks++;
      if (obs() !== exp_vec('0, oh(w), 1'b1)) begin
        n_fail++;
        $display("FAIL all_req_ack%0d: got %h want %h", i, obs(), exp_vec('0, oh(w), 1'b1));
      end
      req = req & ~oh(w);
      tick();
      n_checks++;
      if (obs() !== exp_vec('0, '0, 1'b0)) begin
        n_fail++;
        $display("FAIL all_req_idle%0d: got %h want %h", i, obs(), exp_vec('0, '0, 1'b0));
      end
    end
    n_checks++;
    if (wr_cnt !== 8'd4) begin
      n_fail++;
      $display("FAIL all_req_count: got %0d want 4", wr_cnt);
    end
  endtask

  task automatic test_fairness();
    int w;
    req = 4'b0100;
    dsl[0] = 10'h2a5;
    dsl[2] = 10'h13c;
    for (int t = 0; t < 3; t++) begin
      w = model_pick(req);
      tick();
      n_checks++;
      if (obs() !== exp_vec(oh(w), '0, 1'b1)) begin
        n_fail++;
        $display("FAIL fair_grant%0d: got %h want %h", t, obs(), exp_vec(oh(w), '0, 1'b1));
      end
      tick();
      model_grant_edge(w, 1'b1);
      n_checks++;
      if (obs() !== exp_vec('0, oh(w), 1'b1)) begin
        n_fail++;
        $display("FAIL fair_ack%0d: got %h want %h", t, obs(), exp_vec('0, oh(w), 1'b1));
      end
      req = req & ~oh(w);
      if (t == 0) req = 4'b0101;
      tick();
      n_checks++;
      if (obs() !== exp_vec('0, '0, 1'b0)) begin
        n_fail++;
        $display("FAIL fair_idle%0d: got %h want %h", t, obs(), exp_vec('0, '0, 1'b0));
      end
    end
  endtask

  task automatic test_abort();
    int w;
    dsl[1] = 10'h3ff;
    req    = 4'b0010;
    w      = model_pick(req);
    tick();
    n_checks++;
    if (obs() !== exp_vec(4'b0010, '0, 1'b1)) begin
      n_fail++;
      $display("FAIL abort_grant: got %h want %h", obs(), exp_vec(4'b0010, '0, 1'b1));
    end
    req = '0;
    tick();
    model_grant_edge(w, 1'b0);
    n_checks++;
    if (obs() !== exp_vec('0, '0, 1'b0)) begin
      n_fail++;
      $display("FAIL abort_idle: got %h want %h", obs(), exp_vec('0, '0, 1'b0));
    end
    req = '1;
    w   = model_pick(req);
    tick();
    n_checks++;
    if (gnt !== 4'b0100) begin
      n_fail++;
      $display("FAIL abort_ptr: got gnt=%b want %b", gnt, 4'b0100);
    end
    tick();
    model_grant_edge(w, 1'b1);
    req = '0;
    tick();
    n_checks++;
    if (obs() !== exp_vec('0, '0, 1'b0)) begin
      n_fail++;
      $display("FAIL abort_after: got %h want %h", obs(), exp_vec('0, '0, 1'b0));
    end
  endtask

  task automatic test_reset_mid();
    for (int ph = 0; ph < 2; ph++) begin
      dsl[0] = N'($urandom_range(1023, 1));
      req    = 4'b0001;
      tick();
      if (ph == 1) begin
        tick();
        model_grant_edge(0, 1'b1);
        n_checks++;
        if (obs() !== exp_vec('0, 4'b0001, 1'b1)) begin
          n_fail++;
          $display("FAIL mid_ack_pre: got %h want %h", obs(), exp_vec('0, 4'b0001, 1'b1));
        end
      end
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      n_checks++;
      if (obs() !== exp_vec('0, '0, 1'b0)) begin
        n_fail++;
        $display("FAIL mid_reset_ph%0d: got %h want %h", ph, obs(), exp_vec('0, '0, 1'b0));
      end
      req = '0;
      #1;
      rst = 1'b0;
      tick();
      n_checks++;
      if (obs() !== exp_vec('0, '0, 1'b0)) begin
        n_fail++;
        $display("FAIL mid_after_ph%0d: got %h want %h", ph, obs(), exp_vec('0, '0, 1'b0));
      end
    end
  endtask

  task automatic test_random();
    int w;
    bit abort;
    for (int it = 0; it < 60; it++) begin
      for (int i = 0; i < M; i++) if (!req[i]) dsl[i] = N'($urandom_range(1023));
      req = req | M'($urandom_range((1 << M) - 1));
      if (req == '0) req = oh($urandom_range(M - 1));
      w     = model_pick(req);
      abort = ($urandom_range(3) == 0);
      tick();
      n_checks++;
      if (obs() !== exp_vec(oh(w), '0, 1'b1)) begin
        n_fail++;
        $display("FAIL rand_grant it%0d: got %h want %h", it, obs(), exp_vec(oh(w), '0, 1'b1));
      end
      if ($urandom_range(1) == 1) dsl[w] = N'($urandom_range(1023));
      if (abort) req = req & ~oh(w);
      tick();
      model_grant_edge(w, !abort);
      n_checks++;
      if (obs() !== exp_vec('0, abort ? '0 : oh(w), !abort) || ((gnt != '0) && (ack != '0))) begin
        n_fail++;
        $display("FAIL rand_done it%0d: got %h want %h", it, obs(), exp_vec('0, abort ? '0 : oh(w), !abort));
      end
      if (!abort) begin
        req = req & ~oh(w);
        tick();
        n_checks++;
        if (obs() !== exp_vec('0, '0, 1'b0)) begin
          n_fail++;
          $display("FAIL rand_idle it%0d: got %h want %h", it, obs(), exp_vec('0, '0, 1'b0));
        end
      end
    end
    req = '0;
    tick();
    tick();
  endtask

  task automatic test_wrap();
    int w;
    pulse_reset("wrap_reset");
    for (int k = 0; k < 256; k++) begin
      w      = k % M;
      dsl[w] = N'($urandom_range(1023));
      req    = oh(w);
      tick();
      tick();
      model_grant_edge(w, 1'b1);
      n_checks++;
      if (obs() !== exp_vec('0, oh(w), 1'b1)) begin
        n_fail++;
        $display("FAIL wrap_ack%0d: got %h want %h", k, obs(), exp_vec('0, oh(w), 1'b1));
      end
      req = '0;
      tick();
    end
    n_checks++;
    if (wr_cnt !== '0 || wr_cnt_w !== 2'd0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_final: got cnt=%0d cnt2=%0d busy=%b want 0 0 0", wr_cnt, wr_cnt_w, busy);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_all_request();
    test_fairness();
    test_abort();
    test_reset_mid();
    test_random();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
